// File: rtl/mem_data_pkg.sv
// Shared encodings for the data RAM / MMIO block: access sizes, MMIO byte
// offsets and the controller state type.
package mem_data_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] MMIO_IN    = 32'd0;
  localparam logic [31:0] MMIO_OUT   = 32'd4;
  localparam logic [31:0] MMIO_EDGE  = 32'd8;
  localparam logic [31:0] MMIO_IRQEN = 32'd12;
  localparam logic [31:0] MMIO_END   = 32'd16;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

endpackage

// File: rtl/io_sync_edge.sv
// Input synchroniser for the asynchronous io_in pins, plus a per-bit change
// pulse (synchronised value differs from its value one cycle earlier).
module io_sync_edge #(
  parameter int unsigned IO_W        = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_sync,
  output logic [IO_W-1:0] io_chg
);

  logic [IO_W-1:0] sync_q [SYNC_STAGES];
  logic [IO_W-1:0] prev_q;

  // Synchroniser chain and previous-value register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign io_sync = sync_q[SYNC_STAGES-1];
  assign io_chg  = io_sync ^ prev_q;

endmodule

// File: rtl/mem_data_ram_mmio.sv
// Big-endian byte-addressable data RAM with memory-mapped IO for the RV32E
// load/store port. Sized accesses, registered load data with a valid strobe,
// error pulse on illegal accesses, RAM swept to zero after every reset.
module mem_data_ram_mmio
  import mem_data_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 128,
  parameter int unsigned IO_W        = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            we,
  input  logic [1:0]      size,
  input  logic            load_unsigned,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic            ready,
  output logic            rvalid,
  output logic [31:0]     rdata,
  output logic            err,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic            irq
);

  localparam int unsigned NW = MEM_BYTES / 4;
  localparam int unsigned AW = $clog2(NW);
  localparam logic [1:0] W_IN    = MMIO_IN[3:2];
  localparam logic [1:0] W_OUT   = MMIO_OUT[3:2];
  localparam logic [1:0] W_EDGE  = MMIO_EDGE[3:2];
  localparam logic [1:0] W_IRQEN = MMIO_IRQEN[3:2];

  state_t        state, state_nxt;
  logic [AW-1:0] clr_idx, clr_idx_nxt;

  logic [31:0]     ram [NW];
  logic [IO_W-1:0] io_sync, io_chg;
  logic [IO_W-1:0] out_r, edge_r, irqen_r, edge_clr;

  logic          accept, bad, is_mmio, ram_we, mmio_we;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   wmask, wval, rword, ld_val;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;

  io_sync_edge #(
    .IO_W       (IO_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_io_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .io_in  (io_in),
    .io_sync(io_sync),
    .io_chg (io_chg)
  );

  assign ready   = (state == IDLE);
  assign accept  = req && ready;
  assign is_mmio = (addr < MMIO_END);
  assign widx    = addr[AW+1:2];
  // Big-endian: byte offset 0 lives in the most significant lane.
  assign lane    = 2'd3 - addr[1:0];
  assign ram_we  = accept && we && !bad && !is_mmio;
  assign mmio_we = accept && we && !bad && is_mmio;

  // Access legality check.
  always_comb begin
    bad = 1'b0;
    if (size == 2'b11)                               bad = 1'b1;
    if (size == SZ_HALF && addr[0])                  bad = 1'b1;
    if (size == SZ_WORD && addr[1:0] != 2'b00)       bad = 1'b1;
    if (addr >= 32'(MEM_BYTES))                      bad = 1'b1;
    if (is_mmio && size != SZ_WORD)                  bad = 1'b1;
  end

  // Store lane mask and data placed into its big-endian lane(s).
  always_comb begin
    wmask = '0;
    wval  = '0;
    case (size)
      SZ_BYTE: begin
        wmask[{lane, 3'b000} +: 8] = 8'hFF;
        wval[{lane, 3'b000} +: 8]  = wdata[7:0];
      end
      SZ_HALF: begin
        wmask[{~addr[1], 4'b0000} +: 16] = 16'hFFFF;
        wval[{~addr[1], 4'b0000} +: 16]  = wdata[15:0];
      end
      default: begin
        wmask = '1;
        wval  = wdata;
      end
    endcase
  end

  // Read word selection and sign/zero extension for sub-word loads.
  always_comb begin
    rword = '0;
    if (is_mmio) begin
      case (addr[3:2])
        W_IN:    rword = 32'(io_sync);
        W_OUT:   rword = 32'(out_r);
        W_EDGE:  rword = 32'(edge_r);
        W_IRQEN: rword = 32'(irqen_r);
        default: rword = '0;
      endcase
    end else begin
      rword = ram[widx];
    end
    ld_b = rword[{lane, 3'b000} +: 8];
    ld_h = rword[{~addr[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: ld_val = load_unsigned ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
      SZ_HALF: ld_val = load_unsigned ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_val = rword;
    endcase
  end

  // RAM array: clear sweep or masked store; not reset, the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      ram[clr_idx] <= '0;
    end else if (ram_we) begin
      ram[widx] <= (ram[widx] & ~wmask) | (wval & wmask);
    end
  end

  // Controller state and clear-sweep word pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= AW'(4);
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // Next-state: sweep words 4..NW-1, then serve accesses.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + AW'(1);
        if (clr_idx == AW'(NW - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered load response and error strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= accept && !we;
      err    <= accept && bad;
      if (accept && !we) rdata <= bad ? '0 : ld_val;
    end
  end

  // EDGE write-1-to-clear; a new change in the same cycle wins over the clear.
  assign edge_clr = (mmio_we && addr[3:2] == W_EDGE) ? wdata[IO_W-1:0] : '0;

  // MMIO registers and the registered interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_r   <= '0;
      edge_r  <= '0;
      irqen_r <= '0;
      irq     <= 1'b0;
    end else begin
      if (mmio_we && addr[3:2] == W_OUT)   out_r   <= wdata[IO_W-1:0];
      if (mmio_we && addr[3:2] == W_IRQEN) irqen_r <= wdata[IO_W-1:0];
      edge_r <= (edge_r & ~edge_clr) | io_chg;
      irq    <= |(edge_r & irqen_r);
    end
  end

  assign io_out = out_r;

endmodule

// File: tb/tb_mem_data_ram_mmio.sv
// Directed self-checking bench for mem_data_ram_mmio (default parameters).
module tb_mem_data_ram_mmio;
  import mem_data_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, rvalid, err, irq;
  logic [31:0] rdata;
  logic [7:0]  io_in = '0;
  logic [7:0]  io_out;

  int total = 0;
  int bad = 0;

  mem_data_ram_mmio #(
    .MEM_BYTES  (128),
    .IO_W       (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .we           (we),
    .size         (size),
    .load_unsigned(load_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .ready        (ready),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .err          (err),
    .io_in        (io_in),
    .io_out       (io_out),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: driven at negedge, accepted at next posedge, outputs sampled #1 later.
  task automatic access(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; load_unsigned = uns; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_io_out", {24'd0, io_out}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    wait_ready("clear_len", 28);

    for (int a = 16; a < 128; a += 4) begin
      access(1'b0, SZ_WORD, 1'b0, 32'(a), 32'd0);
      check("clear_word", rdata, 32'd0);
    end

    access(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8123_45F6);
    check("st_word_rvalid", {31'd0, rvalid}, 32'd0);
    check("st_word_err", {31'd0, err}, 32'd0);
    access(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'd0);
    check("ld_byte_s", rdata, 32'hFFFF_FF81);
    access(1'b0, SZ_HALF, 1'b1, 32'h12, 32'd0);
    check("ld_half_u", rdata, 32'h0000_45F6);
    access(1'b0, SZ_HALF, 1'b0, 32'h10, 32'd0);
    check("ld_half_s", rdata, 32'hFFFF_8123);
    access(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'd0);
    check("ld_byte_u", rdata, 32'h0000_00F6);
    access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0);
    check("ld_word", rdata, 32'h8123_45F6);
    check("ld_word_rvalid", {31'd0, rvalid}, 32'd1);
    @(posedge clk);
    #1;
    check("rvalid_pulse", {31'd0, rvalid}, 32'd0);

    access(1'b1, SZ_HALF, 1'b0, 32'h14, 32'h0000_ABCD);
    access(1'b1, SZ_BYTE, 1'b0, 32'h17, 32'h0000_0011);
    access(1'b0, SZ_WORD, 1'b0, 32'h14, 32'd0);
    check("subword_store", rdata, 32'hABCD_0011);

    access(1'b0, SZ_HALF, 1'b0, 32'h11, 32'd0);
    check("mis_half_err", {31'd0, err}, 32'd1);
    check("mis_half_rvalid", {31'd0, rvalid}, 32'd1);
    check("mis_half_rdata", rdata, 32'd0);
    access(1'b1, SZ_WORD, 1'b0, 32'h22, 32'hFFFF_FFFF);
    check("mis_word_st_err", {31'd0, err}, 32'd1);
    check("mis_word_st_rvalid", {31'd0, rvalid}, 32'd0);
    access(1'b0, SZ_WORD, 1'b0, 32'h20, 32'd0);
    check("mis_word_unchanged", rdata, 32'd0);
    check("ok_err_low", {31'd0, err}, 32'd0);
    access(1'b0, SZ_WORD, 1'b0, 32'h80, 32'd0);
    check("range_err", {31'd0, err}, 32'd1);
    check("range_rdata", rdata, 32'd0);
    access(1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    check("size11_err", {31'd0, err}, 32'd1);
    @(posedge clk);
    #1;
    check("err_pulse", {31'd0, err}, 32'd0);

    access(1'b1, SZ_WORD, 1'b0, 32'h4, 32'h0000_00A5);
    check("io_out_set", {24'd0, io_out}, 32'h0000_00A5);
    access(1'b1, SZ_BYTE, 1'b0, 32'h7, 32'h0000_00FF);
    check("mmio_byte_err", {31'd0, err}, 32'd1);
    check("mmio_byte_keep", {24'd0, io_out}, 32'h0000_00A5);
    access(1'b0, SZ_WORD, 1'b0, 32'h4, 32'd0);
    check("out_readback", rdata, 32'h0000_00A5);

    access(1'b1, SZ_WORD, 1'b0, 32'hC, 32'h0000_0001);
    @(negedge clk);
    io_in[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check("irq_latency", {31'd0, irq}, (k == 4) ? 32'd1 : 32'd0);
    end
    access(1'b0, SZ_WORD, 1'b0, 32'h8, 32'd0);
    check("edge_set", rdata, 32'd1);
    access(1'b1, SZ_WORD, 1'b0, 32'h8, 32'd1);
    check("irq_hold_at_clear", {31'd0, irq}, 32'd1);
    @(posedge clk);
    #1;
    check("irq_cleared", {31'd0, irq}, 32'd0);
    access(1'b0, SZ_WORD, 1'b0, 32'h8, 32'd0);
    check("edge_cleared", rdata, 32'd0);

    @(negedge clk);
    io_in[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    access(1'b1, SZ_WORD, 1'b0, 32'h8, 32'd1);
    access(1'b0, SZ_WORD, 1'b0, 32'h8, 32'd0);
    check("set_wins", rdata, 32'd1);

    @(negedge clk);
    io_in = 8'h3C;
    repeat (4) @(posedge clk);
    access(1'b0, SZ_WORD, 1'b0, 32'h0, 32'd0);
    check("in_read", rdata, 32'h0000_003C);
    access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0);
    check("pre_reset_word", rdata, 32'h8123_45F6);

    @(negedge clk);
    req = 1'b1; we = 1'b0; size = SZ_WORD; addr = 32'h10;
    @(posedge clk);
    #2;
    req = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    check("midrst_io_out", {24'd0, io_out}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_ready("clear_len_again", 28);
    access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0);
    check("recleared_word", rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
